fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory (`ram`). It owns the program counter and drives the word address into the memory. It captures the memory's read data into an instruction register and presents it, with its PC and a valid flag, to decode. It supports stall, branch/jump redirect, address wrap-around and an optional halt-on-sentinel stop.

## Interface
Parameters:
- `DEPTH`, 1024: instruction memory depth in words; must be a power of two.
- `RESET_PC`, 0: word address loaded into the PC on reset.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous reset, active high.
- `stall`  in  1  hold the PC and all instruction outputs.
- `redirect`  in  1  load `redirect_pc` and squash the word in flight.
- `redirect_pc`  in  32  redirect target, word address.
- `mem_addr`  out  32  to `ram` ADDRESS; combinational copy of the PC.
- `mem_we`  out  1  to `ram` WE; constant 0.
- `mem_q`  in  32  from `ram` Q; valid at each rising edge for the `mem_addr` held since the preceding rising edge.
- `instr`  out  32  fetched instruction word (registered).
- `instr_pc`  out  32  word address of `instr` (registered).
- `instr_valid`  out  1  `instr` and `instr_pc` are meaningful this cycle.
- `halted`  out  1  fetch has stopped on the sentinel word.

## Operation
- PC width is log2(DEPTH). `mem_addr` is the PC zero-extended to 32 bits; upper bits are always 0.
- FSM states:
  - `BOOT`: the single cycle after reset. No capture; `instr_valid` stays 0. Next state is `RUN`.
  - `RUN`: normal fetch.
  - `HALT`: only when the halt macro is defined.
- Per-edge priority in `RUN`: `Reset` > `redirect` > `stall` > advance.
- Advance:
  - `instr <= mem_q`, `instr_pc <= PC`, `instr_valid <= 1`.
  - `PC <= PC + 1`; when the PC is DEPTH-1, it wraps to 0.
- Redirect:
  - `PC <= redirect_pc[log2(DEPTH)-1:0]`; upper target bits are discarded.
  - `instr_valid <= 0`; `instr` and `instr_pc` keep their old values.
  - Redirect wins over a simultaneous `stall`.
- Stall: PC, `instr`, `instr_pc` and `instr_valid` all hold. `mem_addr` is unchanged, so the memory re-reads the same word.
- `redirect` and `stall` are ignored in `BOOT`.
- Reset values: PC = `RESET_PC`, `instr` = 0, `instr_pc` = 0, `instr_valid` = 0, `halted` = 0, state = `BOOT`. Reset mid-stall or mid-redirect discards all pending work.

## Timing
- PC-to-`instr` latency is 1 cycle:
  - rising edge t: PC = A;
  - falling edge: the memory reads word A;
  - rising edge t+1: `instr` = mem[A], `instr_pc` = A, `instr_valid` = 1.
- After `Reset` is released at edge r:
  - edge r+1: `BOOT` to `RUN`, no output;
  - edge r+2: first valid word, mem[RESET_PC].
- Redirect issued at edge t:
  - edge t: `instr_valid` = 0;
  - edge t+1: the target word is captured. One bubble in total.
- Sustained throughput is 1 word per cycle with no stall or redirect.

## Configuration
- `FETCH_HALT_EN` defined:
  - In `RUN`, when the captured `mem_q` equals `HALT_WORD` (32'hFFFF_FFFF), the word is still presented with `instr_valid` = 1.
  - The FSM then enters `HALT`. On the next edge `instr_valid` goes to 0 and `halted` goes to 1.
  - In `HALT` the PC is frozen, and `redirect` and `stall` are ignored. Only `Reset` leaves `HALT`.
  - If `redirect` is asserted on the capture edge, it wins and no halt occurs.
- `FETCH_HALT_EN` undefined: there is no `HALT` state, `halted` is tied to 0, and 32'hFFFF_FFFF is an ordinary word.

## Structure
- Package `fetch_pkg` holds:
  - the FSM state encoding (`BOOT`, `RUN`, `HALT`);
  - `HALT_WORD`;
  - the default `RESET_PC`.
- Sub-module `fetch_pc_reg` holds the PC register, with load (redirect), hold (stall) and increment-with-wrap modulo DEPTH. It is parameterised by `DEPTH` and `RESET_PC`.
- `fetch_unit` holds the FSM, the instruction and PC capture registers, and the halt detection.

## Test plan
- Memory preloaded with mem[i] = i + 0x100, then release reset: no valid word on edge r+1; from edge r+2 the bench sees (`instr_pc`, `instr`) = (0, 0x100), (1, 0x101), (2, 0x102), each with `instr_valid` = 1.
- Assert `stall` for 3 cycles while `instr_pc` = 2: `instr` holds 0x102 with `instr_valid` = 1. The first word after release is PC 3, 0x103. No words are lost or duplicated.
- `redirect` = 1 with `redirect_pc` = 0x40 together with `stall` = 1: one cycle with `instr_valid` = 0, then (0x40, 0x140). The redirect overrides the stall.
- `RESET_PC` = 1022 with DEPTH = 1024: the sequence is 1022, 1023, 0, 1. `redirect_pc` = 0x405 loads PC 5.
- `FETCH_HALT_EN` with mem[3] = 0xFFFF_FFFF: word 3 is presented once with `instr_valid` = 1. The next edge gives `halted` = 1 and `instr_valid` = 0, `mem_addr` stays at 4, and a later redirect is ignored. `Reset` clears `halted`.
- Assert `Reset` while in `RUN` with `instr_valid` = 1: on the next edge every output returns to its reset value and `mem_addr` = `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, halt sentinel, default reset PC.
// Pure declarations; no timing or flow control of its own.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0]  HALT_WORD        = 32'hFFFF_FFFF;
  localparam int unsigned  DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: load has priority over increment; increment wraps modulo DEPTH.
// Zero latency to o_pc after the edge; holding both controls low freezes the PC (stall/halt).
module fetch_pc_reg #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned RESET_PC = 0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_pc,
  input  logic          i_adv,
  output logic [AW-1:0] o_pc
);

  localparam logic [AW-1:0] RST_PC  = AW'(RESET_PC);
  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  logic [AW-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RST_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_adv) begin
      r_pc <= (r_pc == LAST_PC) ? '0 : r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures ram Q one cycle after the address; optional FETCH_HALT_EN stop.
// stall freezes PC and outputs; redirect reloads the PC with a single bubble.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  input  logic [31:0] mem_q,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_state_e  r_state;
  logic [31:0]   r_instr;
  logic [31:0]   r_instr_pc;
  logic          r_instr_valid;
  logic [AW-1:0] w_pc;
  logic          w_run;
  logic          w_pc_load;
  logic          w_pc_adv;
  logic          w_unused_redirect_hi;

  // Only RUN moves the PC; BOOT and HALT both leave it untouched.
  assign w_run     = (r_state == RUN);
  assign w_pc_load = w_run && redirect;
  assign w_pc_adv  = w_run && !redirect && !stall;

  assign w_unused_redirect_hi = ^redirect_pc[31:AW];

  fetch_pc_reg #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk     (CLK),
    .i_rst     (Reset),
    .i_load    (w_pc_load),
    .i_load_pc (redirect_pc[AW-1:0]),
    .i_adv     (w_pc_adv),
    .o_pc      (w_pc)
  );

`ifdef FETCH_HALT_EN
  logic r_halted;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state       <= BOOT;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (redirect) begin
            r_instr_valid <= 1'b0;
          end else if (!stall) begin
            r_instr       <= mem_q;
            r_instr_pc    <= {{(32-AW){1'b0}}, w_pc};
            r_instr_valid <= 1'b1;
            // The sentinel itself is still delivered; the stop takes effect next edge.
            if (mem_q == HALT_WORD) r_state <= HALT;
          end
        end
        HALT: begin
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign halted = r_halted;
`else
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state       <= BOOT;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (redirect) begin
            r_instr_valid <= 1'b0;
          end else if (!stall) begin
            r_instr       <= mem_q;
            r_instr_pc    <= {{(32-AW){1'b0}}, w_pc};
            r_instr_valid <= 1'b1;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign halted = 1'b0;
`endif

  assign mem_addr    = {{(32-AW){1'b0}}, w_pc};
  assign mem_we      = 1'b0;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances (RESET_PC 0 and 1022) against a transaction model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned RPC1  = 1022;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        boot;
    logic        stop;
    logic        halted;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;
  } model_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] addr   [2];
  logic        we     [2];
  logic [31:0] q      [2];
  logic [31:0] instr  [2];
  logic [31:0] ipc    [2];
  logic        valid  [2];
  logic        halted [2];

  logic [31:0] mem [DEPTH];
  model_t      m   [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(addr[0]), .mem_we(we[0]), .mem_q(q[0]),
    .instr(instr[0]), .instr_pc(ipc[0]), .instr_valid(valid[0]), .halted(halted[0])
  );

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC1)) dut1 (
    .CLK(CLK), .Reset(Reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(addr[1]), .mem_we(we[1]), .mem_q(q[1]),
    .instr(instr[1]), .instr_pc(ipc[1]), .instr_valid(valid[1]), .halted(halted[1])
  );

  // The instruction ram reads on the falling edge, so Q is settled by the next rising edge.
  always @(negedge CLK) begin
    q[0] <= mem[addr[0][9:0]];
    q[1] <= mem[addr[1][9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rising edge of the fetch stage seen as a transaction on the word stream.
  function automatic model_t model_step(input model_t s, input int unsigned rst_pc, input bit rst,
                                        input bit redir, input logic [31:0] rpc, input bit stl,
                                        input logic [31:0] word);
    model_t n = s;
    if (rst) begin
      n.pc = rst_pc; n.boot = 1'b1; n.stop = 1'b0; n.halted = 1'b0;
      n.instr = '0; n.ipc = '0; n.valid = 1'b0;
    end else if (s.boot) begin
      n.boot = 1'b0;
    end else if (s.stop) begin
      n.valid = 1'b0;
      n.halted = 1'b1;
    end else if (redir) begin
      n.pc = rpc % DEPTH;
      n.valid = 1'b0;
    end else if (!stl) begin
      n.instr = word;
      n.ipc   = s.pc;
      n.valid = 1'b1;
      n.pc    = (s.pc + 1) % DEPTH;
      n.stop  = HALT_EN && (word == 32'hFFFF_FFFF);
    end
    return n;
  endfunction

  task automatic cycle();
    @(posedge CLK);
    for (int d = 0; d < 2; d++)
      m[d] = model_step(m[d], (d == 0) ? 0 : RPC1, Reset, redirect, redirect_pc, stall, mem[m[d].pc[9:0]]);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_mem_addr", d), addr[d], m[d].pc);
      check($sformatf("d%0d_mem_we", d), {31'b0, we[d]}, 32'h0);
      check($sformatf("d%0d_valid", d), {31'b0, valid[d]}, {31'b0, m[d].valid});
      check($sformatf("d%0d_instr", d), instr[d], m[d].instr);
      check($sformatf("d%0d_instr_pc", d), ipc[d], m[d].ipc);
      check($sformatf("d%0d_halted", d), {31'b0, halted[d]}, {31'b0, m[d].halted});
    end
  endtask

  initial begin
    Reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = i + 32'h100;
    m[0] = '0;
    m[1] = '0;
    repeat (2) cycle();
    check("rst_valid", {31'b0, valid[0]}, 32'h0);
    check("rst_addr1", addr[1], 32'd1022);

    // Release: boot edge, then words 0,1,2 (and 1022,1023,0 on the second instance).
    Reset = 1'b0;
    cycle();
    check("boot_no_valid", {31'b0, valid[0]}, 32'h0);
    cycle();
    check("first_pc", ipc[0], 32'd0);
    check("first_word", instr[0], 32'h100);
    check("first_pc_d1", ipc[1], 32'd1022);
    cycle();
    check("wrap_1023", ipc[1], 32'd1023);
    cycle();
    check("third_word", instr[0], 32'h102);
    check("wrap_0", ipc[1], 32'd0);

    stall = 1'b1;
    repeat (3) cycle();
    check("stall_hold", instr[0], 32'h102);
    check("stall_valid", {31'b0, valid[0]}, 32'h1);
    stall = 1'b0;
    cycle();
    check("after_stall", ipc[0], 32'd3);
    check("after_stall_w", instr[0], 32'h103);
    check("wrap_1", ipc[1], 32'd1);

    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    cycle();
    check("redir_bubble", {31'b0, valid[0]}, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    cycle();
    check("redir_pc", ipc[0], 32'h40);
    check("redir_word", instr[0], 32'h140);

    redirect = 1'b1; redirect_pc = 32'h405;
    cycle();
    redirect = 1'b0;
    cycle();
    check("redir_trunc", ipc[0], 32'd5);
    check("redir_trunc_d1", ipc[1], 32'd5);
    cycle();

    // Reset while words are flowing.
    Reset = 1'b1;
    cycle();
    check("mid_rst_valid", {31'b0, valid[0]}, 32'h0);
    check("mid_rst_instr", instr[0], 32'h0);
    check("mid_rst_addr", addr[0], 32'h0);
    mem[3] = 32'hFFFF_FFFF;
    cycle();
    Reset = 1'b0;
    repeat (5) cycle();
    check("sentinel_word", instr[0], 32'hFFFF_FFFF);
    check("sentinel_valid", {31'b0, valid[0]}, 32'h1);
    cycle();
`ifdef FETCH_HALT_EN
    check("halt_flag", {31'b0, halted[0]}, 32'h1);
    check("halt_valid", {31'b0, valid[0]}, 32'h0);
    check("halt_addr", addr[0], 32'd4);
`else
    check("no_halt_flag", {31'b0, halted[0]}, 32'h0);
    check("no_halt_next", ipc[0], 32'd4);
`endif
    redirect = 1'b1; redirect_pc = 32'h20;
    cycle();
    redirect = 1'b0;
    cycle();
`ifdef FETCH_HALT_EN
    check("halt_ignores_redir", addr[0], 32'd4);
`else
    check("redir_after_sentinel", ipc[0], 32'h20);
`endif
    Reset = 1'b1;
    cycle();
    check("rst_clears_halt", {31'b0, halted[0]}, 32'h0);

    // Random traffic over a random image with occasional sentinel words.
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFF : $urandom;
    cycle();
    Reset = 1'b0;
    for (int k = 0; k < 600; k++) begin
      Reset       = ($urandom_range(0, 49) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
